// File: rtl/ddr_read_fifo.sv
// ddr_read_fifo
//   Captures 16-bit read beats from the DDR read datapath into a
//   first-word-fall-through FIFO. The FIFO tags the final beat of every
//   BURST_LEN burst. It also flags short bursts and overflow, and presents the
//   stored words to the system side with a valid/ready handshake.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 4)
//   AW        pointer width, log2(DEPTH)
//   BURST_LEN beats per read burst
//
// Ports
//   clk, rst       clock; asynchronous active-low reset
//   data_in_rdy    beat-valid from the read datapath
//   data_in        read beat, sampled while data_in_rdy=1
//   sys_rd_valid   head word valid (fifo_count != 0)
//   sys_rd_data    head word
//   sys_rd_last    head word is the last beat of a burst
//   sys_rd_ready   system pops the head word
//   burst_done     one-cycle pulse after a full burst has been captured
//   short_burst    sticky: data_in_rdy dropped mid-burst
//   overflow       sticky: beat arrived on a full FIFO and was dropped
//   err_clr        synchronous clear of the sticky flags (set wins)
//   fifo_count     stored entries, 0..DEPTH
//   sys_rd_par     (DDR_RD_PARITY_EN only) even parity {hi byte, lo byte}
//
// Build option
//   DDR_RD_PARITY_EN  stores per-byte even parity with every entry
module ddr_read_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_in_rdy,
  input  logic [15:0]   data_in,
  output logic          sys_rd_valid,
  output logic [15:0]   sys_rd_data,
  output logic          sys_rd_last,
  input  logic          sys_rd_ready,
  output logic          burst_done,
  output logic          short_burst,
  output logic          overflow,
  input  logic          err_clr,
  output logic [AW:0]   fifo_count
`ifdef DDR_RD_PARITY_EN
  ,
  output logic [1:0]    sys_rd_par
`endif
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  typedef struct packed {
`ifdef DDR_RD_PARITY_EN
    logic [1:0]  par;
`endif
    logic [15:0] data;
    logic        last;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  entry_t         wr_ent;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  beat_cnt;
  state_t         state;
  logic           full, pop, wr_en, last_tag;
  logic           short_set, ovf_set;

  assign full         = (fifo_count == FULL_CNT);
  assign sys_rd_valid = (fifo_count != '0);
  // Empty FIFO ignores ready, so a fresh write is never popped the same cycle.
  assign pop          = sys_rd_valid & sys_rd_ready;
  // On a full FIFO a beat is only stored if the head leaves in the same cycle.
  assign wr_en        = data_in_rdy & (~full | pop);
  // beat_cnt is zero in IDLE/DONE, so this also covers beat 0 of a new burst.
  assign last_tag     = (beat_cnt == LAST_BEAT);
  assign short_set    = (state == CAPTURE) & ~data_in_rdy;
  assign ovf_set      = data_in_rdy & full & ~pop;

  always_comb begin
    wr_ent      = '0;
    wr_ent.data = data_in;
    wr_ent.last = last_tag;
`ifdef DDR_RD_PARITY_EN
    wr_ent.par  = {^data_in[15:8], ^data_in[7:0]};
`endif
  end

  assign head        = mem[rd_ptr];
  assign sys_rd_data = head.data;
  assign sys_rd_last = sys_rd_valid & head.last;
`ifdef DDR_RD_PARITY_EN
  assign sys_rd_par  = sys_rd_valid ? head.par : 2'b00;
`endif

  // Storage is not reset; validity comes from fifo_count alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Burst framing runs independently of FIFO fullness, so dropped beats
  // still advance beat_cnt and framing stays aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      burst_done  <= 1'b0;
      short_burst <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (data_in_rdy) begin
            if (BURST_LEN == 1) begin
              state      <= DONE;
              burst_done <= 1'b1;
              beat_cnt   <= '0;
            end else begin
              state    <= CAPTURE;
              beat_cnt <= CW'(1);
            end
          end else begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (data_in_rdy) begin
            if (beat_cnt == LAST_BEAT) begin
              state      <= DONE;
              burst_done <= 1'b1;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end else begin
            // Words already stored stay; no last tag is applied after the fact.
            state    <= IDLE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase

      if (short_set)    short_burst <= 1'b1;
      else if (err_clr) short_burst <= 1'b0;
      if (ovf_set)      overflow    <= 1'b1;
      else if (err_clr) overflow    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_read_fifo.sv
// tb_ddr_read_fifo
//   Directed bench for ddr_read_fifo. A queue model tracks stored words and
//   burst position and is compared against the DUT every cycle. Literal
//   checks at key points pin both the model and the DUT.
module tb_ddr_read_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BL    = 4;

  logic        clk;
  logic        rst;
  logic        data_in_rdy;
  logic [15:0] data_in;
  logic        sys_rd_valid;
  logic [15:0] sys_rd_data;
  logic        sys_rd_last;
  logic        sys_rd_ready;
  logic        burst_done;
  logic        short_burst;
  logic        overflow;
  logic        err_clr;
  logic [AW:0] fifo_count;
`ifdef DDR_RD_PARITY_EN
  logic [1:0]  sys_rd_par;
`endif

  ddr_read_fifo #(.DEPTH(DEPTH), .AW(AW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in_rdy  (data_in_rdy),
    .data_in      (data_in),
    .sys_rd_valid (sys_rd_valid),
    .sys_rd_data  (sys_rd_data),
    .sys_rd_last  (sys_rd_last),
    .sys_rd_ready (sys_rd_ready),
    .burst_done   (burst_done),
    .short_burst  (short_burst),
    .overflow     (overflow),
    .err_clr      (err_clr),
    .fifo_count   (fifo_count)
`ifdef DDR_RD_PARITY_EN
    ,
    .sys_rd_par   (sys_rd_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    logic [15:0] d;
    logic        l;
  } ent_t;

  ent_t q[$];
  int   pos;
  logic exp_done, exp_short, exp_ovf;
  logic m_pop, m_full, m_tag, m_sset, m_oset;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      pos       = 0;
      exp_done  = 1'b0;
      exp_short = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      m_pop    = (q.size() != 0) && sys_rd_ready;
      m_full   = (q.size() == DEPTH);
      m_sset   = 1'b0;
      m_oset   = 1'b0;
      exp_done = 1'b0;
      if (m_pop) void'(q.pop_front());
      if (data_in_rdy) begin
        m_tag = (pos == BL - 1);
        if (!m_full || m_pop) q.push_back('{data_in, m_tag});
        else m_oset = 1'b1;
        exp_done = m_tag;
        pos = (pos + 1) % BL;
      end else begin
        m_sset = (pos != 0);
        pos = 0;
      end
      exp_short = m_sset || (exp_short && !err_clr);
      exp_ovf   = m_oset || (exp_ovf && !err_clr);
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (rst && burst_done) done_cnt++;

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("valid", 32'(sys_rd_valid), 32'(q.size() != 0));
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("burst_done", 32'(burst_done), 32'(exp_done));
    chk("short_burst", 32'(short_burst), 32'(exp_short));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (q.size() != 0) begin
      chk("data", 32'(sys_rd_data), 32'(q[0].d));
      chk("last", 32'(sys_rd_last), 32'(q[0].l));
`ifdef DDR_RD_PARITY_EN
      chk("par", 32'(sys_rd_par), 32'({^q[0].d[15:8], ^q[0].d[7:0]}));
`endif
    end else begin
      chk("last_empty", 32'(sys_rd_last), 32'(0));
    end
  endtask

  // One clock: model check at negedge, then return 2 time units after posedge.
  task automatic step();
    @(negedge clk);
    if (rst) compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [15:0] d);
    data_in     = d;
    data_in_rdy = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    data_in_rdy = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  int base;

  initial begin
    rst = 1'b0; data_in_rdy = 1'b0; data_in = '0; sys_rd_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", 32'(sys_rd_valid), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_flags", 32'({burst_done, short_burst, overflow, sys_rd_last}), 32'(0));
    rst = 1'b1;
    idle(2);

    // single burst, then drain
    base = done_cnt;
    beat(16'h1111); beat(16'h2222); beat(16'h3333); beat(16'h4444);
    chk("t1_done_now", 32'(burst_done), 32'(1));
    idle(1);
    chk("t1_count", 32'(fifo_count), 32'(4));
    chk("t1_head", 32'(sys_rd_data), 32'h1111);
    chk("t1_done_once", 32'(done_cnt - base), 32'(1));
    sys_rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_pop_data", 32'(sys_rd_data), 32'(16'h1111 * (i + 1)));
      chk("t1_pop_last", 32'(sys_rd_last), 32'(i == 3));
      step();
    end
    chk("t1_empty", 32'(sys_rd_valid), 32'(0));

    // write into empty FIFO while ready is high: not popped that cycle
    beat(16'hE0E0);
    chk("empty_wr_count", 32'(fifo_count), 32'(1));
    idle(1);
    chk("empty_wr_popped", 32'(fifo_count), 32'(0));
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    sys_rd_ready = 1'b0;

    // back-to-back bursts
    base = done_cnt;
    for (int i = 1; i <= 8; i++) beat(16'(i));
    idle(2);
    chk("t2_done_twice", 32'(done_cnt - base), 32'(2));
    chk("t2_short", 32'(short_burst), 32'(0));
    chk("t2_count", 32'(fifo_count), 32'(8));
    sys_rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_data", 32'(sys_rd_data), 32'(i + 1));
      chk("t2_last", 32'(sys_rd_last), 32'((i % 4) == 3));
      step();
    end
    sys_rd_ready = 1'b0;

    // short burst
    base = done_cnt;
    beat(16'hAAAA); beat(16'hBBBB);
    idle(2);
    chk("t3_short", 32'(short_burst), 32'(1));
    chk("t3_count", 32'(fifo_count), 32'(2));
    chk("t3_no_done", 32'(done_cnt - base), 32'(0));
    sys_rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("t3_last", 32'(sys_rd_last), 32'(0));
      step();
    end
    sys_rd_ready = 1'b0;
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("t3_clr", 32'(short_burst), 32'(0));

    // overflow: 5 bursts into 16 entries
    for (int i = 0; i < 20; i++) beat(16'h0100 + 16'(i));
    idle(1);
    chk("t4_count", 32'(fifo_count), 32'(16));
    chk("t4_ovf", 32'(overflow), 32'(1));
    chk("t4_head", 32'(sys_rd_data), 32'h0100);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'(0));
    // full FIFO with simultaneous pop and write
    sys_rd_ready = 1'b1;
    beat(16'h0999);
    chk("t4_full_count", 32'(fifo_count), 32'(16));
    chk("t4_full_noovf", 32'(overflow), 32'(0));
    data_in_rdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("t4_data", 32'(sys_rd_data), 32'(16'h0101 + 16'(i)));
      step();
    end
    chk("t4_tail", 32'(sys_rd_data), 32'h0999);
    step();
    chk("t4_drained", 32'(sys_rd_valid), 32'(0));
    sys_rd_ready = 1'b0;

    // reset mid-burst
    beat(16'h7001); beat(16'h7002);
    data_in_rdy = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_valid", 32'(sys_rd_valid), 32'(0));
    chk("t5_count", 32'(fifo_count), 32'(0));
    chk("t5_flags", 32'({short_burst, overflow, burst_done}), 32'(0));
    idle(2);
    rst = 1'b1;
    idle(1);
    base = done_cnt;
    for (int i = 1; i <= 4; i++) beat(16'h5000 + 16'(i));
    idle(1);
    chk("t5_done", 32'(done_cnt - base), 32'(1));
    sys_rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_data", 32'(sys_rd_data), 32'(16'h5001 + 16'(i)));
      chk("t5_last", 32'(sys_rd_last), 32'(i == 3));
      step();
    end
    sys_rd_ready = 1'b0;

`ifdef DDR_RD_PARITY_EN
    beat(16'h0301);
    idle(1);
    chk("par_0301", 32'(sys_rd_par), 32'(2'b01));
    sys_rd_ready = 1'b1; idle(1); sys_rd_ready = 1'b0;
    beat(16'hFF00);
    idle(1);
    chk("par_ff00", 32'(sys_rd_par), 32'(2'b00));
    sys_rd_ready = 1'b1; idle(2); sys_rd_ready = 1'b0;
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
